// File: rtl/pwm_compare_if.sv
// Duty configuration channel: valid/ready handshake carrying a requested duty.
// The master offers cfg_duty with cfg_valid; the slave signals room with cfg_ready.
interface pwm_compare_if #(
  parameter int WIDTH = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH:0]   cfg_duty;

  modport master (
    output cfg_valid,
    output cfg_duty,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_duty,
    output cfg_ready
  );
endinterface

// File: rtl/pwm_compare.sv
// Compare-stage PWM generator fed by an upstream WIDTH-bit up counter.
// Produces a registered PWM from (cnt_in < active_duty), a one-cycle tick on
// each counter wrap, and double-buffers duty updates so a new duty only takes
// effect at a wrap while the generator is running.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_OFF  | output forced low; accepted duty is applied immediately
//  ST_RUN  | generating PWM; no duty update outstanding
//  ST_PEND | generating PWM; shadow duty waits for the next wrap
module pwm_compare #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_en,
  input  logic             run,
  pwm_compare_if.slave     cfg,
  output logic             pwm_out,
  output logic             period_tick,
  output logic [WIDTH:0]   active_duty
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   DUTY_FULL = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] CNT_LAST  = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH:0]   active_q, active_d;
  logic [WIDTH:0]   shadow_q, shadow_d;
  logic             ready_q, ready_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic             accept;
  logic             cmp_high;
  logic [WIDTH:0]   duty_clamped;

  // Handshake, wrap detection, duty clamp and the raw compare.
  always_comb begin
    wrap         = cnt_en && (cnt_in == CNT_LAST);
    accept       = cfg.cfg_valid && ready_q;
    cmp_high     = ({1'b0, cnt_in} < active_q);
    duty_clamped = (cfg.cfg_duty > DUTY_FULL) ? DUTY_FULL : cfg.cfg_duty;
  end

  // Next-state and next-output logic; run=0 always wins over a pending wrap.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    ready_d  = ready_q;
    pwm_d    = 1'b0;
    tick_d   = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (accept) begin
          active_d = duty_clamped;
        end
        if (run) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        tick_d = wrap;
        if (!run) begin
          state_d = ST_OFF;
          if (accept) begin
            active_d = duty_clamped;
          end
        end else begin
          pwm_d = cmp_high;
          if (accept) begin
            if (wrap) begin
              // Arrives exactly at the period boundary: no need to buffer.
              active_d = duty_clamped;
            end else begin
              shadow_d = duty_clamped;
              ready_d  = 1'b0;
              state_d  = ST_PEND;
            end
          end
        end
      end

      ST_PEND: begin
        tick_d = wrap;
        if (!run) begin
          active_d = shadow_q;
          ready_d  = 1'b1;
          state_d  = ST_OFF;
        end else begin
          pwm_d = cmp_high;
          if (wrap) begin
            active_d = shadow_q;
            ready_d  = 1'b1;
            state_d  = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_OFF;
      active_q <= '0;
      shadow_q <= '0;
      ready_q  <= 1'b1;
      pwm_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      ready_q  <= ready_d;
      pwm_q    <= pwm_d;
      tick_q   <= tick_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign pwm_out       = pwm_q;
  assign period_tick   = tick_q;
  assign active_duty   = active_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Directed bench for pwm_compare with a cycle-level reference model and
// literal checks on duty counts, boundaries and handshake behaviour.
module tb_pwm_compare;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cnt_in = 4'd0;
  logic       cnt_en = 1'b0;
  logic       run = 1'b0;
  logic       pwm_out;
  logic       period_tick;
  logic [4:0] active_duty;

  pwm_compare_if #(.WIDTH(4)) cfg_if ();

  pwm_compare #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_in      (cnt_in),
    .cnt_en      (cnt_en),
    .run         (run),
    .cfg         (cfg_if.slave),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .active_duty (active_duty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit auto_cnt = 1'b0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: generator is idle, running, or running with a queued duty.
  bit       m_running = 1'b0;
  bit       m_queued  = 1'b0;
  int       m_active  = 0;
  int       m_queue_v = 0;
  bit       m_pwm     = 1'b0;
  bit       m_tick    = 1'b0;

  always @(posedge clk) begin
    bit wrapped, offered, on;
    int req;
    if (!reset) begin
      m_running = 0; m_queued = 0; m_active = 0; m_queue_v = 0;
      m_pwm = 0; m_tick = 0;
    end else begin
      wrapped = cnt_en && (cnt_in == 4'd15);
      offered = cfg_if.cfg_valid && !m_queued;
      req     = (int'(cfg_if.cfg_duty) > 16) ? 16 : int'(cfg_if.cfg_duty);
      on      = m_running || m_queued;
      m_tick  = on && wrapped;
      m_pwm   = on && run && (int'(cnt_in) < m_active);
      if (!on) begin
        if (offered) m_active = req;
        m_running = run;
      end else if (!run) begin
        if (m_queued) m_active = m_queue_v;
        else if (offered) m_active = req;
        m_running = 0; m_queued = 0;
      end else if (m_queued) begin
        if (wrapped) begin
          m_active = m_queue_v; m_queued = 0; m_running = 1;
        end
      end else if (offered) begin
        if (wrapped) m_active = req;
        else begin
          m_queue_v = req; m_queued = 1; m_running = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("period_tick", int'(period_tick), int'(m_tick));
      chk("active_duty", int'(active_duty), m_active);
      chk("cfg_ready", int'(cfg_if.cfg_ready), int'(!m_queued));
    end
  end

  task automatic step();
    @(negedge clk);
    if (auto_cnt && cnt_en) cnt_in = cnt_in + 4'd1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_cnt(input logic [3:0] v, input string name);
    int guard;
    guard = 0;
    while (cnt_in != v && guard < 40) begin
      step();
      guard++;
    end
    chk({name, "_reached"}, int'(cnt_in == v), 1);
  endtask

  // Counts pwm highs and ticks across 16 consecutive cycles.
  task automatic window(output int highs, output int ticks);
    highs = 0; ticks = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      highs += int'(pwm_out);
      ticks += int'(period_tick);
    end
  endtask

  task automatic send(input int duty);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_duty  = 5'(duty);
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  int hi, tk;

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_duty  = 5'd0;

    // Reset with run asserted and a parked counter.
    reset = 1'b0; cnt_in = 4'd7; run = 1'b1;
    step_n(2);
    chk_en = 1'b1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    chk("rst_active", int'(active_duty), 0);
    chk("rst_ready", int'(cfg_if.cfg_ready), 1);

    // OFF: accept applies immediately.
    reset = 1'b1; run = 1'b0;
    step();
    send(5);
    chk("off_accept_active", int'(active_duty), 5);
    chk("off_accept_ready", int'(cfg_if.cfg_ready), 1);

    // Free-running counter at duty 5.
    cnt_in = 4'd0; cnt_en = 1'b1; auto_cnt = 1'b1; run = 1'b1;
    step_n(18);
    window(hi, tk);
    chk("duty5_highs", hi, 5);
    chk("duty5_ticks", tk, 1);

    // Mid-period update to 12 is buffered until wrap; further offers ignored.
    wait_cnt(4'd8, "t3");
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_duty = 5'd12;
    step();
    cfg_if.cfg_duty = 5'd3;
    step();
    chk("pend_ready", int'(cfg_if.cfg_ready), 0);
    chk("pend_active_held", int'(active_duty), 5);
    step_n(3);
    cfg_if.cfg_valid = 1'b0;
    step_n(20);
    chk("pend_applied", int'(active_duty), 12);
    window(hi, tk);
    chk("duty12_highs", hi, 12);

    // Boundaries: 0%, 100%, and clamp of an oversized request.
    send(0);
    step_n(34);
    window(hi, tk);
    chk("duty0_highs", hi, 0);
    send(16);
    step_n(34);
    window(hi, tk);
    chk("duty16_highs", hi, 16);
    send(20);
    step_n(34);
    chk("clamp_active", int'(active_duty), 16);
    window(hi, tk);
    chk("clamp_highs", hi, 16);

    // Accept coinciding with the wrap updates the same edge.
    wait_cnt(4'd15, "t5");
    send(9);
    chk("wrap_accept_active", int'(active_duty), 9);
    chk("wrap_accept_ready", int'(cfg_if.cfg_ready), 1);

    // Pending duty then run=0: shadow applied, output forced low.
    wait_cnt(4'd5, "t6");
    send(2);
    chk("t6_pend_ready", int'(cfg_if.cfg_ready), 0);
    run = 1'b0;
    step();
    chk("stop_pwm", int'(pwm_out), 0);
    chk("stop_active", int'(active_duty), 2);
    chk("stop_ready", int'(cfg_if.cfg_ready), 1);

    // Reset while pending discards the shadow.
    run = 1'b1;
    step_n(3);
    wait_cnt(4'd3, "t6b");
    send(7);
    chk("t6b_pend_ready", int'(cfg_if.cfg_ready), 0);
    reset = 1'b0;
    step();
    chk("rst_pend_active", int'(active_duty), 0);
    chk("rst_pend_ready", int'(cfg_if.cfg_ready), 1);
    reset = 1'b1;
    step_n(24);
    chk("shadow_discarded", int'(active_duty), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
